seq_divider: RTL



---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 24 ++
 rtl/seq_divider.sv | 134 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: default widths,
// counter width and the controller state encoding.
package div_pkg;

    localparam int DVD_W_DEF = 10;
    localparam int DVS_W_DEF = 5;
    localparam int CNT_W_DEF = $clog2(DVD_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference or restore.
module div_step #(
    parameter int DVS_W = 5
) (
    input  logic [DVS_W:0]   rem_in,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   rem_out,
    output logic             q_bit
);

    localparam int RW = DVS_W + 1;

    logic [DVS_W+1:0] shifted;
    logic [DVS_W+1:0] dvs_ext;

    // One extra bit of headroom so the trial compare never wraps
    assign shifted = {rem_in, bit_in};
    assign dvs_ext = {2'b00, divisor};
    assign q_bit   = (shifted >= dvs_ext);
    assign rem_out = q_bit ? RW'(shifted - dvs_ext) : RW'(shifted);

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider (DVD_W / DVS_W) behind a start/done
// handshake. Define DIV_FASTPATH_EN to finish trivial divisions in one cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W = $clog2(DVD_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DVD_W - 1);

    state_t state, state_next;

    logic [DVD_W-1:0] shreg;
    logic [DVS_W-1:0] dvs_r;
    logic [DVS_W:0]   prem;
    logic [DVS_W:0]   rem_next;
    logic [CNT_W-1:0] count;
    logic             q_bit;
    logic             last_iter;
    logic             fast_hit;
    logic             accept;
    logic             load_res;

    logic [DVD_W-1:0] res_q;
    logic [DVS_W-1:0] res_r;
    logic             res_dbz;
    logic             res_ovf;

    assign last_iter = (count == LAST);

`ifdef DIV_FASTPATH_EN
    assign fast_hit = (divisor == '0) || (dividend < {{(DVD_W-DVS_W){1'b0}}, divisor});
`else
    assign fast_hit = 1'b0;
`endif

    div_step #(.DVS_W(DVS_W)) u_step (
        .rem_in  (prem),
        .bit_in  (shreg[DVD_W-1]),
        .divisor (dvs_r),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = fast_hit ? DONE : RUN;
            RUN:  if (last_iter) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        accept   = (state == IDLE) && start;
        load_res = ((state == RUN) && last_iter) || (accept && fast_hit);
    end

    // Result selection: final iteration output, or the operands on a fast path
    always_comb begin
        res_q   = {shreg[DVD_W-2:0], q_bit};
        res_r   = rem_next[DVS_W-1:0];
        res_dbz = (dvs_r == '0);
`ifdef DIV_FASTPATH_EN
        if (state == IDLE) begin
            res_dbz = (divisor == '0);
            res_q   = '0;
            res_r   = dividend[DVS_W-1:0];
        end
`endif
        if (res_dbz) begin
            res_q = '1;
            res_r = '0;
        end
        res_ovf = res_dbz || (|res_q[DVD_W-1:DVS_W]);
    end

    // Dividend bits leave the top of shreg while quotient bits enter the bottom
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            dvs_r       <= '0;
            prem        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                shreg <= dividend;
                dvs_r <= divisor;
                prem  <= '0;
                count <= '0;
            end else if (state == RUN) begin
                shreg <= {shreg[DVD_W-2:0], q_bit};
                prem  <= rem_next;
                count <= count + 1'b1;
            end
            if (load_res) begin
                quotient    <= res_q;
                remainder   <= res_r;
                div_by_zero <= res_dbz;
                overflow    <= res_ovf;
            end
        end
    end

endmodule
